// File: rtl/tx_link_pkg.sv
// rtl/tx_link_pkg.sv - state encoding, line symbols and sizing helper for the TX link sequencer
package tx_link_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    TRAIN = 2'd1,
    LINK  = 2'd2,
    SKIP  = 2'd3
  } link_state_e;

  localparam logic [7:0] K28_5    = 8'hBC;
  localparam logic [7:0] D16_2    = 8'h50;
  localparam logic [7:0] K28_0    = 8'h1C;
  localparam logic [7:0] IDLE_OFF = 8'h00;

  // Counter width for n states, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_skip_timer.sv
// rtl/tx_skip_timer.sv - free-running clock-compensation interval timer
// Pulses tc_o on the last cycle of each PERIOD-cycle window while enabled.
module tx_skip_timer
  import tx_link_pkg::*;
#(
  parameter int unsigned PERIOD = 1024
) (
  input  logic BitCLK_10,
  input  logic Reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int unsigned   CW   = cnt_width(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tc_o = en_i & ~clr_i & (cnt_q == LAST);

  always_ff @(posedge BitCLK_10 or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tx_link_sequencer.sv
// rtl/tx_link_sequencer.sv - word sequencer in front of the 8b/10b encoder
// Trains the link, then interleaves user words, idle pairs and periodic skip sets.
module tx_link_sequencer
  import tx_link_pkg::*;
#(
  parameter int unsigned TRAIN_LEN   = 64,
  parameter int unsigned SKIP_PERIOD = 1024,
  parameter int unsigned SKIP_LEN    = 2
) (
  input  logic       BitCLK_10,
  input  logic       Reset,
  input  logic       link_en,
  input  logic [7:0] tx_data,
  input  logic       tx_k,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] TxParallel_8,
  output logic       TxDataK,
  output logic       link_up
);

  localparam int unsigned   TW         = cnt_width(TRAIN_LEN);
  localparam int unsigned   SW         = cnt_width(SKIP_LEN);
  localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_LEN - 1);
  localparam logic [SW-1:0] SKIP_LAST  = SW'(SKIP_LEN - 1);

  link_state_e   state_q, state_d;
  logic          phase_q, phase_d;
  logic          skip_pend_q, skip_pend_d;
  logic [TW-1:0] train_cnt_q, train_cnt_d;
  logic [SW-1:0] skip_cnt_q, skip_cnt_d;
  logic [7:0]    word_q, word_d;
  logic          k_q, k_d;
  logic          up_q, up_d;

  logic in_link;
  logic timer_en;
  logic timer_tc;
  logic xfer;

  assign in_link  = (state_q == LINK) || (state_q == SKIP);
  assign timer_en = link_en & in_link;
  assign tx_ready = link_en & (state_q == LINK) & ~phase_q & ~skip_pend_q;
  assign xfer     = tx_valid & tx_ready;

  tx_skip_timer #(
    .PERIOD (SKIP_PERIOD)
  ) u_skip_timer (
    .BitCLK_10 (BitCLK_10),
    .Reset     (Reset),
    .en_i      (timer_en),
    .clr_i     (~timer_en),
    .tc_o      (timer_tc)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    skip_pend_d = skip_pend_q | timer_tc;
    train_cnt_d = train_cnt_q;
    skip_cnt_d  = skip_cnt_q;
    word_d      = IDLE_OFF;
    k_d         = 1'b0;
    up_d        = link_en & in_link;

    if (!link_en) begin
      state_d     = OFF;
      phase_d     = 1'b0;
      skip_pend_d = 1'b0;
      train_cnt_d = '0;
      skip_cnt_d  = '0;
    end else begin
      unique case (state_q)
        OFF: begin
          state_d     = TRAIN;
          train_cnt_d = '0;
        end
        TRAIN: begin
          word_d = K28_5;
          k_d    = 1'b1;
          if (train_cnt_q == TRAIN_LAST) begin
            state_d     = LINK;
            phase_d     = 1'b0;
            train_cnt_d = '0;
          end else begin
            train_cnt_d = train_cnt_q + TW'(1);
          end
        end
        LINK: begin
          // A skip only starts on a pair boundary, so the entry word is already K28.0.
          if (skip_pend_q && !phase_q) begin
            word_d      = K28_0;
            k_d         = 1'b1;
            skip_pend_d = timer_tc;
            if (SKIP_LEN > 1) begin
              state_d    = SKIP;
              skip_cnt_d = SW'(1);
            end
          end else if (xfer) begin
            word_d = tx_data;
            k_d    = tx_k;
          end else begin
            word_d  = phase_q ? D16_2 : K28_5;
            k_d     = ~phase_q;
            phase_d = ~phase_q;
          end
        end
        SKIP: begin
          word_d = K28_0;
          k_d    = 1'b1;
          if (skip_cnt_q == SKIP_LAST) begin
            state_d    = LINK;
            phase_d    = 1'b0;
            skip_cnt_d = '0;
          end else begin
            skip_cnt_d = skip_cnt_q + SW'(1);
          end
        end
        default: begin
          state_d = OFF;
        end
      endcase
    end
  end

  always_ff @(posedge BitCLK_10 or negedge Reset) begin
    if (!Reset) begin
      state_q     <= OFF;
      phase_q     <= 1'b0;
      skip_pend_q <= 1'b0;
      train_cnt_q <= '0;
      skip_cnt_q  <= '0;
      word_q      <= IDLE_OFF;
      k_q         <= 1'b0;
      up_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      skip_pend_q <= skip_pend_d;
      train_cnt_q <= train_cnt_d;
      skip_cnt_q  <= skip_cnt_d;
      word_q      <= word_d;
      k_q         <= k_d;
      up_q        <= up_d;
    end
  end

  assign TxParallel_8 = word_q;
  assign TxDataK      = k_q;
  assign link_up      = up_q;

endmodule

// File: tb/tb_tx_link_sequencer.sv
// tb/tb_tx_link_sequencer.sv - directed scoreboard bench for tx_link_sequencer
module tb_tx_link_sequencer;
  import tx_link_pkg::*;

  logic       BitCLK_10 = 1'b0;
  logic       Reset;
  logic       link_en;
  logic [7:0] tx_data;
  logic       tx_k;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] TxParallel_8;
  logic       TxDataK;
  logic       link_up;

  int   total = 0;
  int   bad   = 0;
  int   lc;
  int   nacc;
  logic ph;
  logic acc;
  logic [7:0] b;
  logic [9:0] exp_q[$];

  // Expected words are {link_up, K, byte}.
  localparam logic [9:0] W_OFF = {2'b00, IDLE_OFF};
  localparam logic [9:0] W_TRN = {2'b01, K28_5};
  localparam logic [9:0] W_I0  = {2'b11, K28_5};
  localparam logic [9:0] W_I1  = {2'b10, D16_2};
  localparam logic [9:0] W_SK  = {2'b11, K28_0};

  always #5 BitCLK_10 = ~BitCLK_10;

  tx_link_sequencer #(
    .TRAIN_LEN   (4),
    .SKIP_PERIOD (16),
    .SKIP_LEN    (2)
  ) dut (
    .BitCLK_10    (BitCLK_10),
    .Reset        (Reset),
    .link_en      (link_en),
    .tx_data      (tx_data),
    .tx_k         (tx_k),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .TxParallel_8 (TxParallel_8),
    .TxDataK      (TxDataK),
    .link_up      (link_up)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One word cycle: drive, check ready, push the expected word, then check it after the edge.
  task automatic step(input logic en, input logic vld, input logic [8:0] kd, input logic exp_rdy,
                      input logic [9:0] other_w, input string tag, output logic accepted);
    logic [9:0] e;
    link_en  = en;
    tx_valid = vld;
    {tx_k, tx_data} = kd;
    #1;
    chk({tag, "/rdy"}, 16'(tx_ready), 16'(exp_rdy));
    accepted = vld & tx_ready;
    exp_q.push_back(accepted ? {1'b1, kd} : other_w);
    @(posedge BitCLK_10);
    #1;
    e = exp_q.pop_front();
    chk({tag, "/word"}, 16'({link_up, TxDataK, TxParallel_8}), 16'(e));
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 9'h000, ~ph, ph ? W_I1 : W_I0, tag, acc);
      ph = ~ph;
      lc++;
    end
  endtask

  task automatic bring_up(input string tag);
    step(1'b1, 1'b0, 9'h000, 1'b0, W_OFF, {tag, "/off"}, acc);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 9'h000, 1'b0, W_TRN, {tag, "/train"}, acc);
    lc = 0;
    ph = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset    = 1'b1;
    link_en  = 1'b0;
    tx_valid = 1'b0;
    tx_k     = 1'b0;
    tx_data  = 8'h00;
    #2 Reset = 1'b0;
    #1;
    chk("reset/data", 16'(TxParallel_8), 16'h0000);
    chk("reset/k", 16'(TxDataK), 16'h0000);
    chk("reset/up", 16'(link_up), 16'h0000);
    chk("reset/rdy", 16'(tx_ready), 16'h0000);
    @(posedge BitCLK_10);
    #1;
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 9'h000, 1'b0, W_OFF, "off-hold", acc);

    // Training then idle pairs
    bring_up("up1");
    idle(4, "idle1");

    // Back-to-back user bytes
    step(1'b1, 1'b1, {1'b0, 8'hA5}, 1'b1, W_I0, "b2b0", acc);
    step(1'b1, 1'b1, {1'b0, 8'h3C}, 1'b1, W_I0, "b2b1", acc);
    step(1'b1, 1'b1, {1'b0, 8'hFF}, 1'b1, W_I0, "b2b2", acc);
    lc = lc + 3;
    idle(9, "idle2");

    // Timer fires with phase 1: the pair completes before the skip
    idle(1, "pair-hold");
    step(1'b1, 1'b0, 9'h000, 1'b0, W_SK, "skip1a", acc);
    step(1'b1, 1'b0, 9'h000, 1'b0, W_SK, "skip1b", acc);
    lc = lc + 2;
    idle(1, "idle3");

    // Valid raised during phase 1
    step(1'b1, 1'b1, {1'b0, 8'h5A}, 1'b0, W_I1, "late0", acc);
    step(1'b1, 1'b1, {1'b0, 8'h5A}, 1'b1, W_I0, "late1", acc);
    lc = lc + 2;
    ph = 1'b0;
    idle(2, "idle4");

    // Continuous stream with periodic skips
    nacc = 0;
    for (int i = 0; i < 44; i++) begin
      b = 8'h20 + 8'(nacc);
      step(1'b1, 1'b1, {1'b0, b}, ((lc % 16) >= 2), W_SK, "stream", acc);
      if (acc) nacc++;
      lc++;
    end
    chk("stream/count", 16'(nacc), 16'd38);

    // Abort in the middle of a skip
    idle(12, "idle5");
    step(1'b1, 1'b0, 9'h000, 1'b0, W_SK, "skip-enter", acc);
    step(1'b0, 1'b0, 9'h000, 1'b0, W_OFF, "skip-abort", acc);
    step(1'b0, 1'b0, 9'h000, 1'b0, W_OFF, "abort-hold", acc);
    bring_up("up2");
    idle(16, "idle6");
    step(1'b1, 1'b0, 9'h000, 1'b0, W_SK, "skip2a", acc);
    step(1'b1, 1'b0, 9'h000, 1'b0, W_SK, "skip2b", acc);
    idle(2, "idle7");

    // Abort in the middle of training
    step(1'b0, 1'b0, 9'h000, 1'b0, W_OFF, "tr-pre", acc);
    step(1'b1, 1'b0, 9'h000, 1'b0, W_OFF, "tr-off", acc);
    step(1'b1, 1'b0, 9'h000, 1'b0, W_TRN, "tr-1", acc);
    step(1'b1, 1'b0, 9'h000, 1'b0, W_TRN, "tr-2", acc);
    step(1'b0, 1'b0, 9'h000, 1'b0, W_OFF, "tr-abort", acc);
    step(1'b0, 1'b0, 9'h000, 1'b0, W_OFF, "tr-hold", acc);
    bring_up("up3");
    idle(4, "idle8");

    // Asynchronous reset during user data
    step(1'b1, 1'b1, {1'b0, 8'h77}, 1'b1, W_I0, "pre-rst", acc);
    tx_valid = 1'b0;
    #3 Reset = 1'b0;
    #1;
    chk("arst/data", 16'(TxParallel_8), 16'h0000);
    chk("arst/k", 16'(TxDataK), 16'h0000);
    chk("arst/up", 16'(link_up), 16'h0000);
    chk("arst/rdy", 16'(tx_ready), 16'h0000);
    @(posedge BitCLK_10);
    #1;
    chk("arst-hold/word", 16'({link_up, TxDataK, TxParallel_8}), 16'(W_OFF));
    Reset = 1'b1;
    step(1'b0, 1'b0, 9'h000, 1'b0, W_OFF, "post-rst", acc);
    step(1'b1, 1'b0, 9'h000, 1'b0, W_OFF, "re-en", acc);
    step(1'b1, 1'b0, 9'h000, 1'b0, W_TRN, "re-train", acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
